// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder family: FSM state encoding and
// a constant-evaluable clog2 used to size bit counters.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of bits needed to represent values 0..value-1 (minimum 0).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder, shared by the team's adder variants.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles,
// with sum/cout published only on the completing edge.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter must hold WIDTH itself, hence WIDTH+1 values.
   localparam int CW = clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_shift;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_s;
   logic             fa_c;

   fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // New sum bit enters at the MSB so the word is aligned after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_one
         assign sum_shift = fa_s;
      end else begin : g_wide
         assign sum_shift = {fa_s, sum_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  sum_sr <= '0;
                  carry  <= cin;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_shift;
               carry  <= fa_c;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  sum   <= sum_shift;
                  cout  <= fa_c;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 1 and 16: stimulus pushes
// expected results, a negedge monitor checks every cycle.
module tb_serial_adder;

   typedef struct {
      logic [64:0] res;
      int          due;
   } exp_t;

   logic        clk;
   int          cyc;
   logic        rstn_v  [3];
   logic        start_v [3];
   logic [63:0] a_v     [3];
   logic [63:0] b_v     [3];
   logic        cin_v   [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic [64:0] res_v   [3];
   logic [64:0] last_res[3];
   exp_t        exp_q   [3][$];

   logic [7:0]  sum8;
   logic        cout8;
   logic [0:0]  sum1;
   logic        cout1;
   logic [15:0] sum16;
   logic        cout16;

   int n_checks;
   int n_fail;
   logic drain_req;
   logic drain_ack;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rstn_v[0]), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
      .cin(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum8), .cout(cout8));
   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rstn_v[1]), .start(start_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
      .cin(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum1), .cout(cout1));
   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rstn_v[2]), .start(start_v[2]), .a(a_v[2][15:0]), .b(b_v[2][15:0]),
      .cin(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum16), .cout(cout16));

   assign res_v[0] = 65'({cout8, sum8});
   assign res_v[1] = 65'({cout1, sum1});
   assign res_v[2] = 65'({cout16, sum16});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wof(input int i);
      return (i == 0) ? 8 : ((i == 1) ? 1 : 16);
   endfunction

   function automatic void chk(input string name, input int i, input logic [64:0] act,
                               input logic [64:0] req);
      n_checks = n_checks + 1;
      if (act !== req) begin
         n_fail = n_fail + 1;
         $display("FAIL %s (width %0d) at cycle %0d: got %h, expected %h",
                  name, wof(i), cyc, act, req);
      end
   endfunction

   // Monitor: the only place DUT outputs are compared.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (!rstn_v[i]) begin
            chk("reset_busy", i, 65'(busy_v[i]), 65'd0);
            chk("reset_done", i, 65'(done_v[i]), 65'd0);
            chk("reset_result", i, res_v[i], 65'd0);
            last_res[i] = '0;
         end else if (done_v[i]) begin
            chk("busy_on_done", i, 65'(busy_v[i]), 65'd0);
            if (exp_q[i].size() == 0) begin
               chk("spurious_done", i, 65'(done_v[i]), 65'd0);
            end else begin
               e = exp_q[i].pop_front();
               chk("result", i, res_v[i], e.res);
               chk("latency", i, 65'(cyc), 65'(e.due));
               $display("width %0d done at cycle %0d: {cout,sum}=%h expected %h",
                        wof(i), cyc, res_v[i], e.res);
            end
            last_res[i] = res_v[i];
         end else begin
            chk("busy", i, 65'(busy_v[i]), 65'(exp_q[i].size() != 0));
            chk("hold", i, res_v[i], last_res[i]);
         end
      end
      if (drain_req && !drain_ack) begin
         for (int i = 0; i < 3; i++) chk("outstanding", i, 65'(exp_q[i].size()), 65'd0);
         drain_ack = 1'b1;
      end
   end

   task automatic align();
      @(negedge clk);
      #1;
   endtask

   // Caller must be at a point where the DUT accepts on the next rising edge.
   task automatic issue(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic c);
      logic [64:0] m;
      exp_t e;
      m = (65'd1 << wof(i)) - 65'd1;
      a_v[i] = a;
      b_v[i] = b;
      cin_v[i] = c;
      start_v[i] = 1'b1;
      @(posedge clk);
      #1;
      start_v[i] = 1'b0;
      e.res = ({1'b0, a} & m) + ({1'b0, b} & m) + 65'(c);
      e.due = cyc + wof(i);
      exp_q[i].push_back(e);
   endtask

   task automatic wait_done(input int i);
      for (int k = 0; k < wof(i) + 4; k++) begin
         @(negedge clk);
         #1;
         if (done_v[i]) return;
      end
      $display("FAIL done_timeout (width %0d) at cycle %0d: got no done, expected one", wof(i), cyc);
      $fatal(1, "done timeout");
   endtask

   initial begin
      cyc = 0;
      n_checks = 0;
      n_fail = 0;
      drain_req = 1'b0;
      drain_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rstn_v[i] = 1'b0;
         start_v[i] = 1'b0;
         a_v[i] = '0;
         b_v[i] = '0;
         cin_v[i] = 1'b0;
         last_res[i] = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) rstn_v[i] = 1'b1;

      // Basic add, then overflow followed by a back-to-back request on done.
      align();
      issue(0, 64'h0F, 64'h01, 1'b0);
      wait_done(0);
      align();
      issue(0, 64'hFF, 64'h01, 1'b0);
      wait_done(0);
      issue(0, 64'hFF, 64'h00, 1'b1);
      wait_done(0);

      // A start pulse during RUN must be ignored.
      align();
      issue(0, 64'h12, 64'h34, 1'b0);
      align();
      a_v[0] = 64'hFF;
      b_v[0] = 64'hFF;
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      wait_done(0);

      // Reset in the middle of RUN discards the operation.
      align();
      issue(0, 64'hAA, 64'h55, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rstn_v[0] = 1'b0;
      exp_q[0].delete();
      repeat (2) @(negedge clk);
      #1;
      rstn_v[0] = 1'b1;
      align();
      issue(0, 64'h37, 64'h4C, 1'b1);
      wait_done(0);

      // WIDTH=1 full-adder truth table.
      for (int k = 0; k < 8; k++) begin
         align();
         issue(1, 64'(k & 1), 64'((k >> 1) & 1), 1'((k >> 2) & 1));
         wait_done(1);
      end

      // WIDTH=16 random, mixing back-to-back and via-IDLE requests.
      align();
      for (int k = 0; k < 1000; k++) begin
         issue(2, 64'($urandom), 64'($urandom), 1'($urandom));
         wait_done(2);
         if ($urandom_range(0, 1) == 0) align();
      end

      align();
      align();
      drain_req = 1'b1;
      for (int k = 0; k < 5 && !drain_ack; k++) @(negedge clk);
      #1;
      if (!drain_ack) begin
         $display("FAIL drain_timeout: got no monitor acknowledge, expected one");
         $fatal(1, "drain timeout");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
